// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall and forward-select generation from E/M/W destination shadows.
module hazard_fwd_ctrl #(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic [1:0]    tuse_rs_D,
  input  logic [1:0]    tuse_rt_D,
  input  logic [AW-1:0] waddr_D,
  input  logic [1:0]    kind_D,
  output logic [1:0]    ForwardA_D,
  output logic [1:0]    ForwardB_D,
  output logic [1:0]    ForwardA_E,
  output logic [1:0]    ForwardB_E,
  output logic          ForwardRT_M,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);
  localparam logic [1:0] K_ALU = 2'd1, K_LOAD = 2'd2, K_LINK = 2'd3;
  logic [AW-1:0] r_waddr_E, r_waddr_M, r_waddr_W, r_rs_E, r_rt_E, r_rt_M;
  logic [1:0]    r_kind_E, r_tnew_E, r_tnew_M;
  logic [CW-1:0] r_stall_cnt;
  logic [1:0]    w_tnew_D;
  logic          w_stall_rs, w_stall_rt;

  function automatic logic hit(input logic [AW-1:0] src, input logic [AW-1:0] waddr);
    return src != '0 && src == waddr;
  endfunction

  // Only the youngest matching stage decides; an older result is shadowed by a newer write.
  function automatic logic stall_src(input logic [AW-1:0] src, input logic [1:0] tuse,
                                     input logic [AW-1:0] wa_e, input logic [1:0] tn_e,
                                     input logic [AW-1:0] wa_m, input logic [1:0] tn_m);
    return tuse == 2'd3 ? 1'b0 : hit(src, wa_e) ? tn_e > tuse : hit(src, wa_m) && tn_m > tuse;
  endfunction

  function automatic logic [1:0] fwd_d(input logic [AW-1:0] src, input logic [1:0] tuse,
                                       input logic [AW-1:0] wa_e, input logic [1:0] kd_e,
                                       input logic [AW-1:0] wa_m, input logic [1:0] tn_m);
    return tuse == 2'd3 ? 2'b00 : hit(src, wa_e) ? (kd_e == K_LINK ? 2'b10 : 2'b00) :
           hit(src, wa_m) && tn_m == 2'd0 ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [AW-1:0] src, input logic [AW-1:0] wa_m,
                                       input logic [1:0] tn_m, input logic [AW-1:0] wa_w);
    return hit(src, wa_m) && tn_m == 2'd0 ? 2'b01 : hit(src, wa_w) ? 2'b10 : 2'b00;
  endfunction

  always_comb begin
    w_tnew_D    = kind_D == K_LOAD ? 2'd2 : kind_D == K_ALU ? 2'd1 : 2'd0;
    w_stall_rs  = stall_src(rs_D, tuse_rs_D, r_waddr_E, r_tnew_E, r_waddr_M, r_tnew_M);
    w_stall_rt  = stall_src(rt_D, tuse_rt_D, r_waddr_E, r_tnew_E, r_waddr_M, r_tnew_M);
    stall       = w_stall_rs | w_stall_rt;
    ForwardA_D  = fwd_d(rs_D, tuse_rs_D, r_waddr_E, r_kind_E, r_waddr_M, r_tnew_M);
    ForwardB_D  = fwd_d(rt_D, tuse_rt_D, r_waddr_E, r_kind_E, r_waddr_M, r_tnew_M);
    ForwardA_E  = fwd_e(r_rs_E, r_waddr_M, r_tnew_M, r_waddr_W);
    ForwardB_E  = fwd_e(r_rt_E, r_waddr_M, r_tnew_M, r_waddr_W);
    ForwardRT_M = hit(r_rt_M, r_waddr_W);
    stall_cnt   = r_stall_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_waddr_E   <= '0;
      r_waddr_M   <= '0;
      r_waddr_W   <= '0;
      r_rs_E      <= '0;
      r_rt_E      <= '0;
      r_rt_M      <= '0;
      r_kind_E    <= '0;
      r_tnew_E    <= '0;
      r_tnew_M    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_waddr_E   <= stall ? '0 : waddr_D;
      r_rs_E      <= stall ? '0 : rs_D;
      r_rt_E      <= stall ? '0 : rt_D;
      r_kind_E    <= stall ? '0 : kind_D;
      r_tnew_E    <= stall ? '0 : w_tnew_D;
      r_waddr_M   <= r_waddr_E;
      r_rt_M      <= r_rt_E;
      r_tnew_M    <= r_tnew_E == 2'd0 ? 2'd0 : r_tnew_E - 2'd1;
      r_waddr_W   <= r_waddr_M;
      r_stall_cnt <= stall && r_stall_cnt != '1 ? r_stall_cnt + CW'(1) : r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed and random checks against an in-flight instruction model.
module tb_hazard_fwd_ctrl;
  logic clk, reset_n;
  logic [4:0] rs_D, rt_D, waddr_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, kind_D;
  logic [1:0] ForwardA_D, ForwardB_D, ForwardA_E, ForwardB_E;
  logic [1:0] s_ForwardA_D, s_ForwardB_D, s_ForwardA_E, s_ForwardB_E;
  logic ForwardRT_M, stall, s_ForwardRT_M, s_stall;
  logic [15:0] stall_cnt;
  logic [1:0] s_stall_cnt;

  hazard_fwd_ctrl u_dut (.clk(clk), .reset_n(reset_n), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .waddr_D(waddr_D), .kind_D(kind_D),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ForwardRT_M(ForwardRT_M), .stall(stall), .stall_cnt(stall_cnt));

  hazard_fwd_ctrl #(.CW(2)) u_sat (.clk(clk), .reset_n(reset_n), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .waddr_D(waddr_D), .kind_D(kind_D),
    .ForwardA_D(s_ForwardA_D), .ForwardB_D(s_ForwardB_D), .ForwardA_E(s_ForwardA_E),
    .ForwardB_E(s_ForwardB_E), .ForwardRT_M(s_ForwardRT_M), .stall(s_stall), .stall_cnt(s_stall_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pipe[0]=E, pipe[1]=M, pipe[2]=W; each entry is the instruction occupying that stage
  typedef struct packed { logic [4:0] wa; logic [1:0] kind; logic [4:0] rs; logic [4:0] rt; } ins_t;
  ins_t pipe [3];
  int checks = 0, errors = 0, c16 = 0, c2 = 0;
  logic e_stall;

  function automatic int tnew(int s);
    int init;
    init = pipe[s].kind == 2'd2 ? 2 : pipe[s].kind == 2'd1 ? 1 : 0;
    return s == 2 ? 0 : (init - s < 0 ? 0 : init - s);
  endfunction

  function automatic bit mt(logic [4:0] src, int s);
    return src != 0 && src == pipe[s].wa;
  endfunction

  function automatic bit st(logic [4:0] src, logic [1:0] tuse);
    if (tuse == 2'd3) return 0;
    for (int s = 0; s < 2; s++) if (mt(src, s)) return tnew(s) > int'(tuse);
    return 0;
  endfunction

  function automatic logic [1:0] fd(logic [4:0] src, logic [1:0] tuse);
    if (tuse == 2'd3) return 2'd0;
    if (mt(src, 0)) return pipe[0].kind == 2'd3 ? 2'd2 : 2'd0;
    if (mt(src, 1)) return tnew(1) == 0 ? 2'd1 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fe(logic [4:0] src);
    if (mt(src, 1) && tnew(1) == 0) return 2'd1;
    if (mt(src, 2)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] wa, input logic [1:0] k,
                       input logic rn);
    rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt; waddr_D = wa; kind_D = k;
    reset_n = rn;
    #1;
    e_stall = st(rs, trs) | st(rt, trt);
    chk("stall", stall, e_stall);
    chk("fwd_a_d", ForwardA_D, fd(rs, trs));
    chk("fwd_b_d", ForwardB_D, fd(rt, trt));
    chk("fwd_a_e", ForwardA_E, fe(pipe[0].rs));
    chk("fwd_b_e", ForwardB_E, fe(pipe[0].rt));
    chk("fwd_rt_m", ForwardRT_M, mt(pipe[1].rt, 2));
    chk("stall_cnt", stall_cnt, c16);
    chk("stall_cnt_sat", s_stall_cnt, c2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      c16 = 0; c2 = 0;
    end else begin
      if (e_stall) begin
        c16 = c16 < 65535 ? c16 + 1 : c16;
        c2  = c2 < 3 ? c2 + 1 : c2;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e_stall ? '0 : {waddr_D, kind_D, rs_D, rt_D};
    end
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 3, 3, 0, 0, 1);
    tick();
  endtask

  initial begin
    rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3; waddr_D = 0; kind_D = 0; reset_n = 0;
    e_stall = 0;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    @(posedge clk); #1;
    // stale state writing r7, then reset with D reading r7
    drive(1, 2, 1, 1, 7, 2, 1); tick();
    drive(3, 4, 1, 1, 7, 1, 1); tick();
    drive(7, 7, 0, 0, 0, 0, 0); tick();
    drive(7, 7, 0, 0, 0, 0, 0); tick();
    drive(0, 7, 3, 0, 0, 0, 1);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_fbd", ForwardB_D, 0);
    tick();
    // ALU to branch
    drive(1, 2, 1, 1, 8, 1, 1); tick();
    drive(3, 8, 0, 0, 0, 0, 1); chk("alu_br_stall", stall, 1); tick();
    drive(3, 8, 0, 0, 0, 0, 1); chk("alu_br_nostall", stall, 0);
    chk("alu_br_fbd", ForwardB_D, 1); chk("alu_br_cnt", stall_cnt, 1); tick();
    // load use
    drive(1, 0, 1, 3, 9, 2, 1); tick();
    drive(9, 2, 1, 1, 4, 1, 1); chk("lu_stall", stall, 1); tick();
    drive(9, 2, 1, 1, 4, 1, 1); chk("lu_release", stall, 0); tick();
    drive(0, 0, 3, 3, 0, 0, 1); chk("lu_fae", ForwardA_E, 2); tick();
    // jal / jr
    drive(0, 0, 3, 3, 31, 3, 1); tick();
    drive(31, 0, 0, 3, 0, 0, 1); chk("jr_stall", stall, 0); chk("jr_fad_e", ForwardA_D, 2); tick();
    drive(0, 0, 3, 3, 31, 3, 1); tick();
    nop();
    drive(31, 0, 0, 3, 0, 0, 1); chk("jr_fad_m", ForwardA_D, 1); tick();
    // store data
    drive(1, 0, 1, 3, 10, 2, 1); tick();
    drive(1, 10, 1, 2, 0, 0, 1); chk("sw_stall0", stall, 0); tick();
    drive(0, 0, 3, 3, 0, 0, 1); chk("sw_stall1", stall, 0); tick();
    drive(0, 0, 3, 3, 0, 0, 1); chk("sw_frtm", ForwardRT_M, 1); tick();
    // register 0
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 1); chk("r0_stall", stall, 0);
    chk("r0_fad", ForwardA_D, 0); chk("r0_fbd", ForwardB_D, 0); tick();
    // saturation: chained loads each reading the previous load's r5
    drive(0, 0, 3, 3, 0, 0, 0); tick();
    for (int i = 0; i < 9; i++) begin
      drive(5, 0, 0, 3, 5, 2, 1); tick();
    end
    drive(0, 0, 3, 3, 0, 0, 1);
    chk("sat_cnt16", stall_cnt, 6); chk("sat_cnt2", s_stall_cnt, 3);
    tick();
    // random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r[4];
      logic [1:0] trs, trt;
      for (int j = 0; j < 3; j++) r[j] = 5'($urandom_range(0, 3));
      r[3] = $urandom_range(0, 9) == 0 ? 5'd31 : r[2];
      trs = $urandom_range(0, 2) == 2 ? 2'd3 : 2'($urandom_range(0, 1));
      trt = 2'($urandom_range(0, 3));
      drive(r[0], r[1], trs, trt, r[3], 2'($urandom_range(0, 3)), $urandom_range(0, 39) != 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
